// File: rtl/return_address_stack_if.sv
// return_address_stack_if: call/return/flush requests and top-of-stack prediction bundle
interface return_address_stack_if #(
    parameter int NBits = 32,
    parameter int DEPTH = 8
);
    logic                     push_i;
    logic                     pop_i;
    logic                     flush_i;
    logic [NBits-1:0]         push_data_i;
    logic [NBits-1:0]         top_o;
    logic                     valid_o;
    logic [$clog2(DEPTH):0]   count_o;
    logic                     overflow_o;

    modport master (
        output push_i, pop_i, flush_i, push_data_i,
        input  top_o, valid_o, count_o, overflow_o
    );

    modport slave (
        input  push_i, pop_i, flush_i, push_data_i,
        output top_o, valid_o, count_o, overflow_o
    );
endinterface

// File: rtl/return_address_stack.sv
// return_address_stack: circular LIFO of return addresses, optional sticky overflow flag under RAS_OVERFLOW_FLAG_EN
module return_address_stack #(
    parameter int NBits = 32,
    parameter int DEPTH = 8
) (
    input logic                 clk,
    input logic                 reset,
    return_address_stack_if.slave ras
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [NBits-1:0] mem [DEPTH];
    logic [AW-1:0]    tos;
    logic [AW-1:0]    next_tos;
    logic [CW-1:0]    count;
    logic             nonempty;
    logic             full;
    logic             swap;

    assign next_tos = tos + 1'b1;
    assign nonempty = count != '0;
    assign full     = count == FULL;
    assign swap     = ras.push_i && ras.pop_i && nonempty;

    // stack pointer, occupancy and entries; a full push wraps over the oldest entry
    always_ff @(posedge clk) begin
        if (reset) begin
            tos   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (ras.flush_i) begin
            count <= '0;
        end else if (swap) begin
            mem[tos] <= ras.push_data_i;
        end else if (ras.push_i) begin
            tos           <= next_tos;
            mem[next_tos] <= ras.push_data_i;
            count         <= full ? count : count + 1'b1;
        end else if (ras.pop_i && nonempty) begin
            tos   <= tos - 1'b1;
            count <= count - 1'b1;
        end
    end

`ifdef RAS_OVERFLOW_FLAG_EN
    logic ovf;

    // sticky flag set whenever a plain push evicts the oldest entry
    always_ff @(posedge clk) begin
        if (reset || ras.flush_i) ovf <= 1'b0;
        else if (ras.push_i && !ras.pop_i && full) ovf <= 1'b1;
    end

    assign ras.overflow_o = ovf;
`else
    assign ras.overflow_o = 1'b0;
`endif

    assign ras.top_o   = nonempty ? mem[tos] : '0;
    assign ras.valid_o = nonempty;
    assign ras.count_o = count;
endmodule

// File: tb/tb_return_address_stack.sv
// tb_return_address_stack: directed stimulus against a queue-based model plus literal checks
module tb_return_address_stack;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    bit   started = 0;
    bit   model_ovf = 0;
    logic [31:0] q [$];

    always #5 clk = ~clk;

    return_address_stack_if #(.NBits(32), .DEPTH(D)) bus ();

    return_address_stack #(.NBits(32), .DEPTH(D)) dut (
        .clk  (clk),
        .reset(reset),
        .ras  (bus)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [31:0] exp_top();
        return q.size() > 0 ? q[q.size()-1] : 32'h0;
    endfunction

    function automatic logic exp_ovf();
`ifdef RAS_OVERFLOW_FLAG_EN
        return model_ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model(input bit p, input bit po, input bit f, input bit r, input logic [31:0] d);
        if (r || f) begin
            q.delete();
            model_ovf = 0;
        end else if (p && po && q.size() > 0) begin
            q[q.size()-1] = d;
        end else if (p) begin
            if (q.size() == D) begin
                void'(q.pop_front());
                model_ovf = 1;
            end
            q.push_back(d);
        end else if (po && q.size() > 0) begin
            void'(q.pop_back());
        end
    endtask

    task automatic cyc(input bit p, input bit po, input bit f, input bit r, input logic [31:0] d);
        bus.push_i      = p;
        bus.pop_i       = po;
        bus.flush_i     = f;
        bus.push_data_i = d;
        reset           = r;
        @(posedge clk);
        model(p, po, f, r, d);
        started = 1;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] d); cyc(1, 0, 0, 0, d); endtask
    task automatic pop();                      cyc(0, 1, 0, 0, 32'h0); endtask

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("model_top",   bus.top_o,              exp_top());
                chk("model_valid", 32'(bus.valid_o),       32'(q.size() > 0));
                chk("model_count", 32'(bus.count_o),       32'(q.size()));
                chk("model_ovf",   32'(bus.overflow_o),    32'(exp_ovf()));
            end
        end
    end

    initial begin
        bus.push_i = 0; bus.pop_i = 0; bus.flush_i = 0; bus.push_data_i = '0; reset = 1;
        @(negedge clk);
        cyc(0, 0, 0, 1, 32'h0);
        chk("rst_top",   bus.top_o, 32'h0);
        chk("rst_valid", 32'(bus.valid_o), 32'h0);
        chk("rst_count", 32'(bus.count_o), 32'h0);
        chk("rst_ovf",   32'(bus.overflow_o), 32'h0);

        push(32'h100); push(32'h200); push(32'h300);
        chk("p3_count", 32'(bus.count_o), 32'd3);
        chk("p3_top",   bus.top_o, 32'h300);
        pop(); chk("pop1_top", bus.top_o, 32'h200);
        pop(); chk("pop2_top", bus.top_o, 32'h100);
        pop(); chk("pop3_valid", 32'(bus.valid_o), 32'h0);
        chk("pop3_top", bus.top_o, 32'h0);

        pop();
        chk("under_count", 32'(bus.count_o), 32'h0);
        chk("under_top",   bus.top_o, 32'h0);
        push(32'h40);
        chk("after_under_top",   bus.top_o, 32'h40);
        chk("after_under_count", 32'(bus.count_o), 32'd1);
        pop();

        push(32'h10); push(32'h20); push(32'h30); push(32'h40); push(32'h50);
        chk("ovf_count", 32'(bus.count_o), 32'd4);
        chk("ovf_top",   bus.top_o, 32'h50);
`ifdef RAS_OVERFLOW_FLAG_EN
        chk("ovf_flag", 32'(bus.overflow_o), 32'h1);
`else
        chk("ovf_flag", 32'(bus.overflow_o), 32'h0);
`endif
        pop(); chk("ovf_pop1", bus.top_o, 32'h40);
        pop(); chk("ovf_pop2", bus.top_o, 32'h30);
        pop(); chk("ovf_pop3", bus.top_o, 32'h20);
        pop(); chk("ovf_pop4_valid", 32'(bus.valid_o), 32'h0);

        push(32'h100); push(32'h200);
        cyc(1, 1, 0, 0, 32'h999);
        chk("swap_count", 32'(bus.count_o), 32'd2);
        chk("swap_top",   bus.top_o, 32'h999);
        pop(); chk("swap_pop_top", bus.top_o, 32'h100);
        pop();
        cyc(1, 1, 0, 0, 32'h777);
        chk("swap_empty_count", 32'(bus.count_o), 32'd1);
        chk("swap_empty_top",   bus.top_o, 32'h777);
        pop();

        for (int i = 1; i <= 5; i++) push(32'(i * 16));
        pop(); pop(); push(32'hAB);
        chk("pre_flush_count", 32'(bus.count_o), 32'd3);
        cyc(1, 0, 1, 0, 32'h123);
        chk("flush_count", 32'(bus.count_o), 32'h0);
        chk("flush_valid", 32'(bus.valid_o), 32'h0);
        chk("flush_ovf",   32'(bus.overflow_o), 32'h0);

        push(32'hA0); push(32'hB0);
        cyc(0, 1, 0, 1, 32'h0);
        chk("mid_rst_top",   bus.top_o, 32'h0);
        chk("mid_rst_count", 32'(bus.count_o), 32'h0);
        chk("mid_rst_valid", 32'(bus.valid_o), 32'h0);
        push(32'hFFFF_FFFC);
        chk("max_top",   bus.top_o, 32'hFFFF_FFFC);
        chk("max_count", 32'(bus.count_o), 32'd1);
        push(32'h0);
        chk("zero_top",   bus.top_o, 32'h0);
        chk("zero_valid", 32'(bus.valid_o), 32'h1);

        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = $urandom_range(0, 15);
            cyc(sel < 7 || sel == 13, sel >= 6 && sel < 13, sel == 14, 1'b0, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
